// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg (package)
// Description : Shared definitions for the inter-stage pipeline registers.
//               - pipe_state_e : 2-bit occupancy encoding of a skid stage.
//                 Bit 0 is the main-register valid bit and bit 1 is the
//                 skid-register valid bit.
//               - Default payload widths of the four processor stage
//                 boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB).
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } pipe_state_e;

    localparam int unsigned IFID_W  = 96;
    localparam int unsigned IDEX_W  = 154;
    localparam int unsigned EXMEM_W = 106;
    localparam int unsigned MEMWB_W = 104;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_data_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_data_reg
// Description : WIDTH-bit load-enabled data register with an asynchronous,
//               active-high reset to RESET_DATA. Holds its value when load
//               is low.
// Ports       : clk   - rising-edge clock
//               reset - asynchronous active-high reset
//               load  - capture d on the next rising edge
//               d     - data input  [WIDTH-1:0]
//               q     - data output [WIDTH-1:0]
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_data_reg
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH      = 96,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= RESET_DATA;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule : pipe_data_reg
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_skid
// Description : Parametrised pipeline stage register with valid/ready
//               handshake, synchronous flush and a 2-entry skid buffer.
//               in_ready is registered, yet full throughput is kept: when
//               the downstream stalls, the one payload already in flight
//               lands in the skid register.
//               Optional feature macro: PIPE_STALL_CNT_EN adds the
//               saturating stall_count output.
// Ports       : clk         - rising-edge clock
//               reset       - asynchronous active-high reset
//               flush       - synchronous bubble request
//               in_valid    - upstream has a payload
//               in_ready    - stage can accept (registered)
//               in_data     - upstream payload [WIDTH-1:0]
//               out_valid   - out_data holds a valid payload
//               out_ready   - downstream accepts this cycle
//               out_data    - payload from the main register [WIDTH-1:0]
//               stall_count - cycles with out_valid & ~out_ready, saturating
//                             [CNT_W-1:0] (PIPE_STALL_CNT_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH      = 96,
    parameter logic [WIDTH-1:0] RESET_DATA = '0,
    parameter int unsigned      CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_count
`endif
);

    // Elaboration-time parameter sanity checks.
    if (WIDTH < 1) begin : g_bad_width
        $error("pipe_stage_skid: WIDTH must be at least 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("pipe_stage_skid: CNT_W must be at least 1");
    end

    pipe_state_e      state_q;
    pipe_state_e      state_d;
    logic             in_ready_q;
    logic             in_ready_d;

    logic             w_main_v;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic             w_main_load;
    logic             w_main_from_skid;
    logic             w_skid_load;
    logic [WIDTH-1:0] w_main_in;
    logic [WIDTH-1:0] w_skid_q;

    // Valid bits are the state bits themselves.
    assign w_main_v   = state_q[0];
    assign w_in_xfer  = in_valid & in_ready_q;
    assign w_out_xfer = w_main_v & out_ready;

    always_comb begin
        state_d          = state_q;
        w_main_load      = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        if (flush) begin
            // Only the valid bits clear; data registers keep their contents.
            // An input offered this cycle is dropped with the upstream flush.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        w_main_load = 1'b1;
                        state_d     = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_in_xfer && w_out_xfer) begin
                        w_main_load = 1'b1;
                    end else if (w_in_xfer) begin
                        // Downstream stalled while in_ready was still high:
                        // park the in-flight payload.
                        w_skid_load = 1'b1;
                        state_d     = ST_FULL;
                    end else if (w_out_xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only the skid drains forward.
                    if (w_out_xfer) begin
                        w_main_load      = 1'b1;
                        w_main_from_skid = 1'b1;
                        state_d          = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
        in_ready_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign w_main_in = w_main_from_skid ? w_skid_q : in_data;

    pipe_data_reg #(
        .WIDTH      (WIDTH),
        .RESET_DATA (RESET_DATA)
    ) u_main_reg (
        .clk   (clk),
        .reset (reset),
        .load  (w_main_load),
        .d     (w_main_in),
        .q     (out_data)
    );

    pipe_data_reg #(
        .WIDTH      (WIDTH),
        .RESET_DATA (RESET_DATA)
    ) u_skid_reg (
        .clk   (clk),
        .reset (reset),
        .load  (w_skid_load),
        .d     (in_data),
        .q     (w_skid_q)
    );

    assign out_valid = w_main_v;
    assign in_ready  = in_ready_q;

`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_count_q;
    logic [CNT_W-1:0] stall_count_d;

    // Saturates at all-ones; flush does not clear it.
    always_comb begin
        stall_count_d = stall_count_q;
        if (w_main_v && !out_ready && !(&stall_count_q)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;
`endif

endmodule : pipe_stage_skid
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_skid
// Description : Self-checking bench for pipe_stage_skid. Two instances
//               (WIDTH=154 and WIDTH=8) share the stimulus; a negedge
//               monitor keeps one scoreboard queue per instance and checks
//               ordering and output stability, while the directed steps
//               check reset, streaming, backpressure, flush, async reset
//               and (with PIPE_STALL_CNT_EN) the stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid;

    localparam int unsigned      WW    = 154;
    localparam int unsigned      NW    = 8;
    localparam logic [WW-1:0]    W_RST = 154'h5A5;
    localparam logic [NW-1:0]    N_RST = 8'h3C;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          out_ready;
    logic [WW-1:0] in_data;

    logic          w_in_ready;
    logic          w_out_valid;
    logic [WW-1:0] w_out_data;
    logic          n_in_ready;
    logic          n_out_valid;
    logic [NW-1:0] n_out_data;
`ifdef PIPE_STALL_CNT_EN
    logic [3:0]    w_stall_count;
    logic [3:0]    n_stall_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [WW-1:0] wq[$];
    logic [NW-1:0] nq[$];
    logic          w_hold = 1'b0;
    logic          n_hold = 1'b0;
    logic [WW-1:0] w_prev = '0;
    logic [NW-1:0] n_prev = '0;
    logic [159:0]  rnd;

    always #5 clk = ~clk;

    pipe_stage_skid #(
        .WIDTH      (WW),
        .RESET_DATA (W_RST),
        .CNT_W      (4)
    ) u_dut_wide (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (w_in_ready),
        .in_data     (in_data),
        .out_valid   (w_out_valid),
        .out_ready   (out_ready),
        .out_data    (w_out_data)
`ifdef PIPE_STALL_CNT_EN
        ,
        .stall_count (w_stall_count)
`endif
    );

    pipe_stage_skid #(
        .WIDTH      (NW),
        .RESET_DATA (N_RST),
        .CNT_W      (4)
    ) u_dut_narrow (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (n_in_ready),
        .in_data     (in_data[NW-1:0]),
        .out_valid   (n_out_valid),
        .out_ready   (out_ready),
        .out_data    (n_out_data)
`ifdef PIPE_STALL_CNT_EN
        ,
        .stall_count (n_stall_count)
`endif
    );

    task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: inputs only change just after posedge, so at the
    // negedge the handshake that the next posedge will act on is settled.
    always @(negedge clk) begin
        if (reset !== 1'b0) begin
            wq.delete();
            nq.delete();
            w_hold = 1'b0;
            n_hold = 1'b0;
        end else begin
            if (w_hold) begin
                check("w_hold_valid", WW'(w_out_valid), WW'(1));
                check("w_hold_data", w_out_data, w_prev);
            end
            if (n_hold) begin
                check("n_hold_valid", WW'(n_out_valid), WW'(1));
                check("n_hold_data", WW'(n_out_data), WW'(n_prev));
            end
            if (w_out_valid && out_ready) begin
                n_checks++;
                assert (wq.size() != 0) else begin
                    n_fail++;
                    $error("FAIL w_sb_extra observed=%0h expected=no_output", w_out_data);
                end
                if (wq.size() != 0) check("w_sb_data", w_out_data, wq.pop_front());
            end
            if (n_out_valid && out_ready) begin
                n_checks++;
                assert (nq.size() != 0) else begin
                    n_fail++;
                    $error("FAIL n_sb_extra observed=%0h expected=no_output", n_out_data);
                end
                if (nq.size() != 0) check("n_sb_data", WW'(n_out_data), WW'(nq.pop_front()));
            end
            if (flush) begin
                wq.delete();
                nq.delete();
            end else begin
                if (in_valid && w_in_ready) wq.push_back(in_data);
                if (in_valid && n_in_ready) nq.push_back(in_data[NW-1:0]);
            end
            w_hold = w_out_valid && !out_ready && !flush;
            n_hold = n_out_valid && !out_ready && !flush;
            w_prev = w_out_data;
            n_prev = n_out_data;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        tick();
        tick();
        @(negedge clk);
        check("rst_valid", WW'(w_out_valid), WW'(0));
        check("rst_ready", WW'(w_in_ready), WW'(1));
        check("rst_data", w_out_data, W_RST);
        check("rst_data_n", WW'(n_out_data), WW'(N_RST));
        tick();
        reset = 1'b0;

        // Streaming: one payload per cycle, 1-cycle latency, no bubbles.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_data = WW'(i);
            @(negedge clk);
            check("stream_ready", WW'(w_in_ready), WW'(1));
            if (i > 1) begin
                check("stream_valid", WW'(w_out_valid), WW'(1));
                check("stream_data", w_out_data, WW'(i - 1));
            end
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("stream_last", w_out_data, WW'(8));
        tick();

        // Backpressure: 0xB lands in skid while 0xA is held.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = WW'('hA);
        tick();
        in_data = WW'('hB);
        @(negedge clk);
        check("bp_a_valid", WW'(w_out_valid), WW'(1));
        check("bp_a_data", w_out_data, WW'('hA));
        check("bp_ready_one", WW'(w_in_ready), WW'(1));
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_ready_full", WW'(w_in_ready), WW'(0));
        check("bp_hold_a", w_out_data, WW'('hA));
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_out_a", w_out_data, WW'('hA));
        tick();
        @(negedge clk);
        check("bp_out_b", w_out_data, WW'('hB));
        check("bp_ready_back", WW'(w_in_ready), WW'(1));
        tick();
        @(negedge clk);
        check("bp_drained", WW'(w_out_valid), WW'(0));

        // Flush while FULL with 0xC offered: 0xC never appears.
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = WW'('h10);
        tick();
        in_data = WW'('h11);
        tick();
        flush   = 1'b1;
        in_data = WW'('hC);
        @(negedge clk);
        check("fl_full_ready", WW'(w_in_ready), WW'(0));
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("fl_valid", WW'(w_out_valid), WW'(0));
        check("fl_ready", WW'(w_in_ready), WW'(1));
        tick();
        in_valid = 1'b1;
        in_data  = WW'('hD);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("fl_d_valid", WW'(w_out_valid), WW'(1));
        check("fl_d_data", w_out_data, WW'('hD));
        tick();
        @(negedge clk);
        check("fl_d_alone", WW'(w_out_valid), WW'(0));

        // Asynchronous reset between clock edges while FULL.
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = WW'('h20);
        tick();
        in_data = WW'('h21);
        tick();
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("ar_valid", WW'(w_out_valid), WW'(0));
        check("ar_ready", WW'(w_in_ready), WW'(1));
        check("ar_data", w_out_data, W_RST);
        check("ar_valid_n", WW'(n_out_valid), WW'(0));
        check("ar_data_n", WW'(n_out_data), WW'(N_RST));
        tick();
        reset = 1'b0;

`ifdef PIPE_STALL_CNT_EN
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = WW'('h30);
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        @(negedge clk);
        check("sc_saturated", WW'(w_stall_count), WW'(15));
        check("sc_saturated_n", WW'(n_stall_count), WW'(15));
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("sc_after_flush", WW'(w_stall_count), WW'(15));
        check("sc_flush_valid", WW'(w_out_valid), WW'(0));
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("sc_after_reset", WW'(w_stall_count), WW'(0));
        tick();
        reset = 1'b0;
`endif

        // Random valid/ready/flush traffic; the monitor does the checking.
        for (int c = 0; c < 10000; c++) begin
            rnd       = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            in_data   = rnd[WW-1:0];
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 99) == 0);
            tick();
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        check("drain_wide_q", WW'(wq.size()), WW'(0));
        check("drain_narrow_q", WW'(nq.size()), WW'(0));
        check("drain_valid", WW'(w_out_valid), WW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pipe_stage_skid
`default_nettype wire
